// File: rtl/mux21_arb_stage.sv
// Two-requester arbiter feeding a registered Mux21 operand/select pair. Capture latency is 1 cycle, and gnt is combinational in the capture cycle.
// A held item stalls while out_ready=0. MUX21_ARB_FIXED_PRIO_EN selects fixed priority to requester 0 instead of round-robin.
module mux21_arb_stage (
  input  logic       CLK,
  input  logic       Reset_L,
  input  logic [1:0] req,
  input  logic [1:0] d,
  input  logic       out_ready,
  output logic [1:0] mux_in,
  output logic       mux_sel,
  output logic       out_valid,
  output logic [1:0] gnt,
  output logic [7:0] gnt_cnt0,
  output logic [7:0] gnt_cnt1
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_mux_in;
  logic       r_mux_sel;
  logic [7:0] r_cnt0;
  logic [7:0] r_cnt1;
  logic       w_ptr;
  logic       w_winner;
  logic       w_capture;

`ifdef MUX21_ARB_FIXED_PRIO_EN
  assign w_ptr = 1'b0;
`else
  logic r_ptr;

  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      r_ptr <= 1'b0;
    end else if (w_capture) begin
      r_ptr <= ~w_winner;
    end
  end

  assign w_ptr = r_ptr;
`endif

  always_comb begin
    w_winner = 1'b0;
    case (req)
      2'b10:   w_winner = 1'b1;
      2'b11:   w_winner = w_ptr;
      default: w_winner = 1'b0;
    endcase
  end

  // Reset gates capture so gnt can never pulse while Reset_L is low.
  assign w_capture = Reset_L && (req != 2'b00) && ((r_state == IDLE) || out_ready);

  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_capture) begin
      w_state_nxt = HOLD;
    end else if ((r_state == HOLD) && out_ready) begin
      w_state_nxt = IDLE;
    end
  end

  always_comb begin
    gnt       = 2'b00;
    out_valid = (r_state == HOLD);
    if (w_capture) begin
      gnt[w_winner] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      r_mux_in  <= 2'b00;
      r_mux_sel <= 1'b0;
    end else if (w_capture) begin
      r_mux_in  <= d;
      r_mux_sel <= w_winner;
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      r_cnt0 <= 8'h00;
      r_cnt1 <= 8'h00;
    end else begin
      if (gnt[0] && (r_cnt0 != 8'hFF)) begin
        r_cnt0 <= r_cnt0 + 8'd1;
      end
      if (gnt[1] && (r_cnt1 != 8'hFF)) begin
        r_cnt1 <= r_cnt1 + 8'd1;
      end
    end
  end

  assign mux_in   = r_mux_in;
  assign mux_sel  = r_mux_sel;
  assign gnt_cnt0 = r_cnt0;
  assign gnt_cnt1 = r_cnt1;

endmodule

// File: tb/tb_mux21_arb_stage.sv
// Scoreboard bench for mux21_arb_stage: expected items are queued at capture and checked while held and when consumed.
module tb_mux21_arb_stage;

  logic       CLK = 1'b0;
  logic       Reset_L;
  logic [1:0] req;
  logic [1:0] d;
  logic       out_ready;
  logic [1:0] mux_in;
  logic       mux_sel;
  logic       out_valid;
  logic [1:0] gnt;
  logic [7:0] gnt_cnt0;
  logic [7:0] gnt_cnt1;

  int total = 0;
  int bad   = 0;

  logic [2:0] sb_q[$];

  logic       m_valid = 1'b0;
  logic       m_ptr   = 1'b0;
  logic       m_sel   = 1'b0;
  logic [1:0] m_in    = 2'b00;
  logic [7:0] m_cnt0  = 8'h00;
  logic [7:0] m_cnt1  = 8'h00;

  mux21_arb_stage dut (
    .CLK       (CLK),
    .Reset_L   (Reset_L),
    .req       (req),
    .d         (d),
    .out_ready (out_ready),
    .mux_in    (mux_in),
    .mux_sel   (mux_sel),
    .out_valid (out_valid),
    .gnt       (gnt),
    .gnt_cnt0  (gnt_cnt0),
    .gnt_cnt1  (gnt_cnt1)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive inputs after negedge, compare, advance across posedge, update the model.
  task automatic step(input logic rst_n, input logic [1:0] r, input logic [1:0] dd, input logic rdy);
    logic       cap;
    logic       win;
    logic [1:0] eg;
    logic [2:0] front;
    logic [1:0] f_in;
    Reset_L   = rst_n;
    req       = r;
    d         = dd;
    out_ready = rdy;
    #1;
    cap = rst_n && (r != 2'b00) && (!m_valid || rdy);
`ifdef MUX21_ARB_FIXED_PRIO_EN
    win = (r == 2'b10);
`else
    win = (r == 2'b10) ? 1'b1 : (r == 2'b11) ? m_ptr : 1'b0;
`endif
    eg = cap ? (win ? 2'b10 : 2'b01) : 2'b00;
    check("gnt", {7'd0, gnt}, {7'd0, eg});
    check("out_valid", {8'd0, out_valid}, {8'd0, m_valid});
    check("gnt_cnt0", {1'b0, gnt_cnt0}, {1'b0, m_cnt0});
    check("gnt_cnt1", {1'b0, gnt_cnt1}, {1'b0, m_cnt1});
    if (!m_valid) begin
      check("idle_regs", {6'd0, mux_sel, mux_in}, {6'd0, m_sel, m_in});
    end else if (sb_q.size() > 0) begin
      front = sb_q[0];
      f_in  = front[1:0];
      check("sb_held", {6'd0, mux_sel, mux_in}, {6'd0, front});
      if (rdy && rst_n) begin
        check("mux_out", {8'd0, mux_in[mux_sel]}, {8'd0, f_in[front[2]]});
        void'(sb_q.pop_front());
      end
    end
    if (!rst_n) sb_q.delete();
    if (cap) sb_q.push_back({win, dd});
    @(posedge CLK);
    if (!rst_n) begin
      m_valid = 1'b0; m_ptr = 1'b0; m_sel = 1'b0; m_in = 2'b00;
      m_cnt0  = 8'h00; m_cnt1 = 8'h00;
    end else if (cap) begin
      m_valid = 1'b1;
      m_sel   = win;
      m_in    = dd;
`ifndef MUX21_ARB_FIXED_PRIO_EN
      m_ptr   = ~win;
`endif
      if (!win && m_cnt0 != 8'hFF) m_cnt0 = m_cnt0 + 8'd1;
      if (win && m_cnt1 != 8'hFF) m_cnt1 = m_cnt1 + 8'd1;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    @(negedge CLK);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset_L = 1'b0; req = 2'b11; d = 2'b11; out_ready = 1'b0;
    @(negedge CLK);
    // Second reset cycle is checked against the cleared model.
    step(1'b0, 2'b11, 2'b11, 1'b0);

    // Single request, then observe the held item, then drain.
    step(1'b1, 2'b01, 2'b01, 1'b1);
    step(1'b1, 2'b00, 2'b00, 1'b0);
    check("mux21_out_single", {8'd0, mux_in[mux_sel]}, 9'd1);
    step(1'b1, 2'b00, 2'b00, 1'b1);
    step(1'b1, 2'b00, 2'b00, 1'b1);

    // Round-robin from a fresh pointer.
    step(1'b0, 2'b00, 2'b00, 1'b0);
    step(1'b1, 2'b11, 2'b01, 1'b1);
    step(1'b1, 2'b11, 2'b10, 1'b1);
    step(1'b1, 2'b11, 2'b11, 1'b1);
    step(1'b1, 2'b11, 2'b00, 1'b1);
`ifndef MUX21_ARB_FIXED_PRIO_EN
    check("rr_cnt0", {1'b0, gnt_cnt0}, 9'd2);
    check("rr_cnt1", {1'b0, gnt_cnt1}, 9'd2);
`else
    check("fixed_cnt1", {1'b0, gnt_cnt1}, 9'd0);
`endif

    // Backpressure while holding sel=1, d=10.
    step(1'b1, 2'b10, 2'b10, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'b01, 2'b01, 1'b0);
      check("bp_mux21_out", {8'd0, mux_in[mux_sel]}, 9'd1);
    end
    step(1'b1, 2'b01, 2'b01, 1'b1);

    // Saturation of requester 0 count, then drain and ignored out_ready in IDLE.
    for (int i = 0; i < 260; i++) step(1'b1, 2'b01, 2'($urandom), 1'b1);
    check("sat_cnt0", {1'b0, gnt_cnt0}, 9'h0FF);
    step(1'b1, 2'b00, 2'b00, 1'b1);
    step(1'b1, 2'b00, 2'b00, 1'b1);
    check("drained", {8'd0, out_valid}, 9'd0);

    // Reset mid-HOLD with ptr pointing at requester 1.
    step(1'b1, 2'b11, 2'b10, 1'b0);
    step(1'b0, 2'b11, 2'b11, 1'b0);
    step(1'b1, 2'b11, 2'b11, 1'b0);

    // Random traffic with occasional reset.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 39) != 0), 2'($urandom), 2'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
